// File: rtl/dvi_timing_pkg.sv
// Shared timing defaults, pipeline flag bundle and sync polarity helper.
// Imported by the axis counter and the sequencer top.
package dvi_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA_640X480_H_ACTIVE = 640;
    localparam int VGA_640X480_H_FP     = 16;
    localparam int VGA_640X480_H_SYNC   = 96;
    localparam int VGA_640X480_H_BP     = 48;
    localparam int VGA_640X480_V_ACTIVE = 480;
    localparam int VGA_640X480_V_FP     = 10;
    localparam int VGA_640X480_V_SYNC   = 2;
    localparam int VGA_640X480_V_BP     = 33;
    localparam int DVI_CW               = 11;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic first;
    } dvi_tflags_t;

    localparam dvi_tflags_t DVI_TFLAGS_IDLE = '{de: 1'b0, hsync: 1'b0, vsync: 1'b0, first: 1'b0};

    // Wire level for a sync signal: an active sync drives the polarity bit.
    function automatic logic sync_level(input logic act, input logic pol);
        return ~(act ^ pol);
    endfunction

endpackage

// File: rtl/dvi_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on step, flags wrap/active/sync region.
// Latency: count is a register; wrap/active/sync_act are combinational from it.
// Backpressure: none, the counter advances on every step.
module dvi_axis_counter
    import dvi_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_640X480_H_ACTIVE,
    parameter int FP     = VGA_640X480_H_FP,
    parameter int SYNC   = VGA_640X480_H_SYNC,
    parameter int BP     = VGA_640X480_H_BP,
    parameter int CW     = DVI_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          sync_act
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_last;

    assign at_last = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (step) begin
            count_d = at_last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign wrap     = step && at_last;
    assign active   = (count_q < ACT_END);
    assign sync_act = (count_q >= SYNC_LO) && (count_q < SYNC_HI);

endmodule

// File: rtl/dvi_timing_sequencer.sv
// DVI raster timing: h/v counters, pixel requests, per-channel data/control/de.
// Latency: counter position reaches enc_* 2 clk later; pix_rgb is expected 1 clk after pix_req.
// Backpressure: none; counters never stall and pix_rgb is sampled every clock.
module dvi_timing_sequencer
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_640X480_H_ACTIVE,
    parameter int H_FP      = VGA_640X480_H_FP,
    parameter int H_SYNC    = VGA_640X480_H_SYNC,
    parameter int H_BP      = VGA_640X480_H_BP,
    parameter int V_ACTIVE  = VGA_640X480_V_ACTIVE,
    parameter int V_FP      = VGA_640X480_V_FP,
    parameter int V_SYNC    = VGA_640X480_V_SYNC,
    parameter int V_BP      = VGA_640X480_V_BP,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = DVI_CW
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_req,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    input  logic [23:0]   pix_rgb,
    output logic          enc_de,
    output logic [1:0]    enc_c0,
    output logic [1:0]    enc_c1,
    output logic [1:0]    enc_c2,
    output logic [7:0]    enc_d0,
    output logic [7:0]    enc_d1,
    output logic [7:0]    enc_d2,
    output logic          frame_start
);

    localparam logic HPOL = 1'(HSYNC_POL);
    localparam logic VPOL = 1'(VSYNC_POL);
    localparam logic [1:0] C0_IDLE = {sync_level(1'b0, VPOL), sync_level(1'b0, HPOL)};

    // ---------------- stage 0: raster counters ----------------
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_active;
    logic          v_active;
    logic          h_sync_act;
    logic          v_sync_act;
    logic          in_active;

    dvi_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_counter (
        .clk      (clk),
        .reset    (reset),
        .step     (1'b1),
        .count    (h_count),
        .wrap     (h_wrap),
        .active   (h_active),
        .sync_act (h_sync_act)
    );

    // v only advances on the h wrap, so vsync edges stay aligned to line starts.
    dvi_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_counter (
        .clk      (clk),
        .reset    (reset),
        .step     (h_wrap),
        .count    (v_count),
        .wrap     (v_wrap),
        .active   (v_active),
        .sync_act (v_sync_act)
    );

    assign in_active = h_active && v_active;
    assign pix_req   = in_active;
    assign pix_x     = in_active ? h_count : '0;
    assign pix_y     = in_active ? v_count : '0;

    // ---------------- stage 1: timing flags ----------------
    dvi_tflags_t s1_q;
    dvi_tflags_t s1_d;

    always_comb begin
        s1_d       = DVI_TFLAGS_IDLE;
        s1_d.de    = in_active;
        s1_d.hsync = h_sync_act;
        s1_d.vsync = v_sync_act;
        s1_d.first = (h_count == '0) && (v_count == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= DVI_TFLAGS_IDLE;
        end else begin
            s1_q <= s1_d;
        end
    end

    // ---------------- stage 2: encoder-facing registers ----------------
    logic       enc_de_q;
    logic       enc_de_d;
    logic [1:0] enc_c0_q;
    logic [1:0] enc_c0_d;
    logic [7:0] enc_d0_q;
    logic [7:0] enc_d0_d;
    logic [7:0] enc_d1_q;
    logic [7:0] enc_d1_d;
    logic [7:0] enc_d2_q;
    logic [7:0] enc_d2_d;
    logic       frame_start_q;
    logic       frame_start_d;

    always_comb begin
        enc_de_d      = s1_q.de;
        enc_c0_d      = {sync_level(s1_q.vsync, VPOL), sync_level(s1_q.hsync, HPOL)};
        frame_start_d = s1_q.first;
        enc_d2_d      = 8'h00;
        enc_d1_d      = 8'h00;
        enc_d0_d      = 8'h00;
        // Blanking data is forced to zero so stale source pixels never leak out.
        if (s1_q.de) begin
            enc_d2_d = pix_rgb[23:16];
            enc_d1_d = pix_rgb[15:8];
            enc_d0_d = pix_rgb[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_de_q      <= 1'b0;
            enc_c0_q      <= C0_IDLE;
            enc_d0_q      <= 8'h00;
            enc_d1_q      <= 8'h00;
            enc_d2_q      <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            enc_de_q      <= enc_de_d;
            enc_c0_q      <= enc_c0_d;
            enc_d0_q      <= enc_d0_d;
            enc_d1_q      <= enc_d1_d;
            enc_d2_q      <= enc_d2_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign enc_de      = enc_de_q;
    assign enc_c0      = enc_c0_q;
    assign enc_c1      = 2'b00;
    assign enc_c2      = 2'b00;
    assign enc_d0      = enc_d0_q;
    assign enc_d1      = enc_d1_q;
    assign enc_d2      = enc_d2_q;
    assign frame_start = frame_start_q;

endmodule
